rotor_chain: RTL

ROTOR_CHAIN -- requirements
Module: rotor_chain

---
 rtl/rotor_chain.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/rotor_chain.sv
// Rotor substitution chain: characters pass through NR configurable rotors,
// one rotor per cycle, with odometer-style position stepping after each result.
//
// state  | meaning
// S_IDLE | ready; accepts set (config write) or valid (character request)
// S_MAP  | one rotor applied per cycle, stage counter k_q = 0..NR-1
// S_DONE | one-cycle result strobe; positions step on exit when no error
module rotor_chain #(
  parameter int NR = 3,
  parameter int ALPHA = 26,
  parameter int CW = 8,
  parameter int BASE = 65,
  localparam int PW = $clog2(ALPHA),
  localparam int IW = (NR > 1) ? $clog2(NR) : 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                set,
  input  logic [IW-1:0]       cfg_idx,
  input  logic [ALPHA*PW-1:0] cfg_wiring,
  input  logic [PW-1:0]       cfg_pos,
  input  logic [PW-1:0]       cfg_notch,
  input  logic                valid,
  input  logic                dec,
  input  logic [CW-1:0]       din,
  output logic                ready,
  output logic                done,
  output logic                err,
  output logic [CW-1:0]       dout
);

  typedef enum logic [1:0] {S_IDLE, S_MAP, S_DONE} state_t;

  localparam logic [PW:0] ALPHA_X = (PW+1)'(ALPHA);

  state_t          state_q, state_d;
  logic [IW-1:0]   k_q, k_d;
  logic [PW-1:0]   c_q, c_d;
  logic            dec_q, dec_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [CW-1:0]   dout_q, dout_d;
  logic [PW-1:0]   wiring_q [NR][ALPHA];
  logic [PW-1:0]   wiring_d [NR][ALPHA];
  logic [PW-1:0]   pos_q [NR];
  logic [PW-1:0]   pos_d [NR];
  logic [PW-1:0]   notch_q [NR];
  logic [PW-1:0]   notch_d [NR];

  logic [IW-1:0]   rot;
  logic [PW-1:0]   p_cur, a_idx, w_val, enc_c, dec_c, stage_c, j_hit;
  logic            found, carry;

  // Both helpers rely on operands already being reduced below ALPHA.
  function automatic logic [PW-1:0] mod_add(input logic [PW-1:0] x, input logic [PW-1:0] y);
    logic [PW:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= ALPHA_X) s = s - ALPHA_X;
    return s[PW-1:0];
  endfunction

  function automatic logic [PW-1:0] mod_sub(input logic [PW-1:0] x, input logic [PW-1:0] y);
    logic [PW:0] s;
    s = {1'b0, x} - {1'b0, y};
    if (x < y) s = s + ALPHA_X;
    return s[PW-1:0];
  endfunction

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    c_d      = c_q;
    dec_d    = dec_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    dout_d   = dout_q;
    wiring_d = wiring_q;
    pos_d    = pos_q;
    notch_d  = notch_q;
    carry    = 1'b0;

    // Decode walks the chain backwards through the inverse wirings.
    rot     = dec_q ? (IW'(NR-1) - k_q) : k_q;
    p_cur   = pos_q[rot];
    a_idx   = mod_add(c_q, p_cur);
    w_val   = wiring_q[rot][a_idx];
    enc_c   = mod_sub(w_val, p_cur);
    found   = 1'b0;
    j_hit   = '0;
    for (int j = ALPHA-1; j >= 0; j--) begin
      if (wiring_q[rot][j] == a_idx) begin
        found = 1'b1;
        j_hit = PW'(j);
      end
    end
    dec_c   = found ? mod_sub(j_hit, p_cur) : c_q;
    stage_c = dec_q ? dec_c : enc_c;

    case (state_q)
      S_IDLE: begin
        if (set) begin
          if (int'(cfg_idx) < NR) begin
            for (int j = 0; j < ALPHA; j++) wiring_d[cfg_idx][j] = cfg_wiring[j*PW +: PW];
            pos_d[cfg_idx]   = cfg_pos;
            notch_d[cfg_idx] = cfg_notch;
          end
        end else if (valid) begin
          dec_d = dec;
          c_d   = PW'(int'(din) - BASE);
          if (int'(din) < BASE || int'(din) >= BASE + ALPHA) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
            dout_d  = din;
          end else begin
            state_d = S_MAP;
            k_d     = '0;
          end
        end
      end
      S_MAP: begin
        c_d = stage_c;
        if (k_q == IW'(NR-1)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          dout_d  = CW'(int'(stage_c) + BASE);
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (!err_q) begin
          // Odometer carry, judged on each rotor's pre-step position.
          carry = 1'b1;
          for (int r = 0; r < NR; r++) begin
            if (carry) begin
              pos_d[r] = mod_add(pos_q[r], PW'(1));
              carry    = (pos_q[r] == notch_q[r]);
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      c_q     <= '0;
      dec_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      dout_q  <= '0;
      for (int r = 0; r < NR; r++) begin
        for (int j = 0; j < ALPHA; j++) wiring_q[r][j] <= PW'(j);
        pos_q[r]   <= '0;
        notch_q[r] <= PW'(ALPHA-1);
      end
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      c_q      <= c_d;
      dec_q    <= dec_d;
      done_q   <= done_d;
      err_q    <= err_d;
      dout_q   <= dout_d;
      wiring_q <= wiring_d;
      pos_q    <= pos_d;
      notch_q  <= notch_d;
    end
  end

  assign ready = (state_q == S_IDLE);
  assign done  = done_q;
  assign err   = err_q;
  assign dout  = dout_q;

endmodule
